// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg
//   Shared types and helpers for the dual-issue scheduler.
//   - NUM_REGISTERS_LOG2 : width of a register specifier
//   - sched_state_t      : scheduler FSM encodings (SCHED_PAIR/SPLIT/STALL)
//   - reg_match()        : register equality that ignores r0
//   - load_hit()         : source operand matches a load sitting in ID/EX
package issue_scheduler_pkg;

   localparam int NUM_REGISTERS_LOG2 = 5;

   typedef enum logic [1:0] {
      SCHED_PAIR  = 2'd0,
      SCHED_SPLIT = 2'd1,
      SCHED_STALL = 2'd2
   } sched_state_t;

   // r0 is hardwired to zero, so it can never carry a dependence.
   function automatic logic reg_match(input logic [NUM_REGISTERS_LOG2-1:0] a,
                                      input logic [NUM_REGISTERS_LOG2-1:0] b);
      return (a != '0) && (a == b);
   endfunction

   function automatic logic load_hit(input logic [NUM_REGISTERS_LOG2-1:0] src,
                                     input logic [NUM_REGISTERS_LOG2-1:0] ex_rd0,
                                     input logic                          ex_ld0,
                                     input logic [NUM_REGISTERS_LOG2-1:0] ex_rd1,
                                     input logic                          ex_ld1);
      return (ex_ld0 && reg_match(src, ex_rd0)) || (ex_ld1 && reg_match(src, ex_rd1));
   endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// pair_hazard_check
//   Purely combinational hazard comparators for the instruction pair in ID.
//   Inputs : slot-0/slot-1 register fields and control flags, ID/EX load
//            destinations.
//   Outputs: pair_conflict - the two slots cannot issue in the same cycle
//            load_use0     - a slot-0 source depends on a load in ID/EX
//            load_use1     - a slot-1 source depends on a load in ID/EX
module pair_hazard_check
   import issue_scheduler_pkg::*;
(
   input  logic [NUM_REGISTERS_LOG2-1:0] rs0,
   input  logic [NUM_REGISTERS_LOG2-1:0] rt0,
   input  logic [NUM_REGISTERS_LOG2-1:0] rd0,
   input  logic                          reg_write0,
   input  logic                          mem_op0,
   input  logic                          branch0,
   input  logic [NUM_REGISTERS_LOG2-1:0] rs1,
   input  logic [NUM_REGISTERS_LOG2-1:0] rt1,
   input  logic [NUM_REGISTERS_LOG2-1:0] rd1,
   input  logic                          reg_write1,
   input  logic                          mem_op1,
   input  logic [NUM_REGISTERS_LOG2-1:0] id_ex_rd0,
   input  logic [NUM_REGISTERS_LOG2-1:0] id_ex_rd1,
   input  logic                          id_ex_mem_read0,
   input  logic                          id_ex_mem_read1,
   output logic                          pair_conflict,
   output logic                          load_use0,
   output logic                          load_use1
);

   logic raw;
   logic waw;

   assign raw = reg_write0 && (reg_match(rs1, rd0) || reg_match(rt1, rd0));
   assign waw = reg_write0 && reg_write1 && reg_match(rd1, rd0);

   // A slot-0 branch must issue alone so slot 1 can be squashed cleanly.
   assign pair_conflict = raw || waw || (mem_op0 && mem_op1) || branch0;

   assign load_use0 = load_hit(rs0, id_ex_rd0, id_ex_mem_read0, id_ex_rd1, id_ex_mem_read1)
                   || load_hit(rt0, id_ex_rd0, id_ex_mem_read0, id_ex_rd1, id_ex_mem_read1);
   assign load_use1 = load_hit(rs1, id_ex_rd0, id_ex_mem_read0, id_ex_rd1, id_ex_mem_read1)
                   || load_hit(rt1, id_ex_rd0, id_ex_mem_read0, id_ex_rd1, id_ex_mem_read1);

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler
//   ID-stage dual-issue scheduler. Decides per cycle whether the decoded
//   pair issues together, issues split over two cycles, or stalls for a
//   load-use hazard, and keeps dual-issue / bubble statistics.
//   Parameters: LOAD_STALL (1..3) bubbles per load-use hazard, CNT_W counter width.
//   Inputs : clk, rst_n (async, active low), pair_valid, slot fields
//            (rs/rt/rd/reg_write/mem_op/branch x2), ID/EX load info, branch_taken.
//   Outputs: issue0, issue1, hold_ifid, bubble (combinational),
//            first (registered ordering bit), dual_cnt, stall_cnt.
module issue_scheduler
   import issue_scheduler_pkg::*;
#(
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 32
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          pair_valid,
   input  logic [NUM_REGISTERS_LOG2-1:0] rs0,
   input  logic [NUM_REGISTERS_LOG2-1:0] rt0,
   input  logic [NUM_REGISTERS_LOG2-1:0] rd0,
   input  logic                          reg_write0,
   input  logic                          mem_op0,
   input  logic                          branch0,
   input  logic [NUM_REGISTERS_LOG2-1:0] rs1,
   input  logic [NUM_REGISTERS_LOG2-1:0] rt1,
   input  logic [NUM_REGISTERS_LOG2-1:0] rd1,
   input  logic                          reg_write1,
   input  logic                          mem_op1,
   input  logic                          branch1,
   input  logic [NUM_REGISTERS_LOG2-1:0] id_ex_rd0,
   input  logic [NUM_REGISTERS_LOG2-1:0] id_ex_rd1,
   input  logic                          id_ex_mem_read0,
   input  logic                          id_ex_mem_read1,
   input  logic                          branch_taken,
   output logic                          issue0,
   output logic                          issue1,
   output logic                          hold_ifid,
   output logic                          bubble,
   output logic                          first,
   output logic [CNT_W-1:0]              dual_cnt,
   output logic [CNT_W-1:0]              stall_cnt
);

   localparam int                STALL_W    = 2;
   localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(LOAD_STALL - 1);
   // The hazard-detect cycle is itself the first bubble; the STALL state
   // supplies the remaining LOAD_STALL-1 bubbles, so it is skipped entirely
   // when a single bubble is enough.
   localparam sched_state_t      STALL_TGT  = (LOAD_STALL > 1) ? SCHED_STALL : SCHED_PAIR;

   sched_state_t       state_reg, state_next;
   sched_state_t       ret_reg, ret_next;
   logic [STALL_W-1:0] stall_ctr_reg, stall_ctr_next;
   logic               first_reg;
   logic [CNT_W-1:0]   dual_cnt_reg;
   logic [CNT_W-1:0]   stall_cnt_reg;

   logic pair_conflict;
   logic load_use0;
   logic load_use1;

   // A slot-1 branch never restricts pairing; it resolves in EX like any other.
   logic unused_branch1;
   assign unused_branch1 = branch1;

   pair_hazard_check u_hazard (
      .rs0             (rs0),
      .rt0             (rt0),
      .rd0             (rd0),
      .reg_write0      (reg_write0),
      .mem_op0         (mem_op0),
      .branch0         (branch0),
      .rs1             (rs1),
      .rt1             (rt1),
      .rd1             (rd1),
      .reg_write1      (reg_write1),
      .mem_op1         (mem_op1),
      .id_ex_rd0       (id_ex_rd0),
      .id_ex_rd1       (id_ex_rd1),
      .id_ex_mem_read0 (id_ex_mem_read0),
      .id_ex_mem_read1 (id_ex_mem_read1),
      .pair_conflict   (pair_conflict),
      .load_use0       (load_use0),
      .load_use1       (load_use1)
   );

   always_comb begin
      state_next     = state_reg;
      ret_next       = ret_reg;
      stall_ctr_next = stall_ctr_reg;
      issue0         = 1'b0;
      issue1         = 1'b0;
      hold_ifid      = 1'b0;
      bubble         = 1'b0;

      // Outputs are held quiet while reset is asserted so a reset that lands
      // mid-stall releases the front end immediately.
      if (!rst_n) begin
         state_next = SCHED_PAIR;
      end else if (branch_taken) begin
         bubble         = 1'b1;
         state_next     = SCHED_PAIR;
         ret_next       = SCHED_PAIR;
         stall_ctr_next = '0;
      end else if (pair_valid) begin
         case (state_reg)
            SCHED_PAIR: begin
               // With a pair conflict only slot 0 is about to issue, so a
               // slot-1 load-use is deferred to the SPLIT cycle.
               if (load_use0 || (!pair_conflict && load_use1)) begin
                  bubble         = 1'b1;
                  hold_ifid      = 1'b1;
                  ret_next       = SCHED_PAIR;
                  stall_ctr_next = STALL_LOAD;
                  state_next     = STALL_TGT;
               end else if (pair_conflict) begin
                  issue0     = 1'b1;
                  hold_ifid  = 1'b1;
                  state_next = SCHED_SPLIT;
               end else begin
                  issue0 = 1'b1;
                  issue1 = 1'b1;
               end
            end
            SCHED_SPLIT: begin
               if (load_use1) begin
                  bubble         = 1'b1;
                  hold_ifid      = 1'b1;
                  ret_next       = SCHED_SPLIT;
                  stall_ctr_next = STALL_LOAD;
                  state_next     = (LOAD_STALL > 1) ? SCHED_STALL : SCHED_SPLIT;
               end else begin
                  issue1     = 1'b1;
                  state_next = SCHED_PAIR;
               end
            end
            SCHED_STALL: begin
               bubble         = 1'b1;
               hold_ifid      = 1'b1;
               stall_ctr_next = stall_ctr_reg - 2'd1;
               if (stall_ctr_reg <= 2'd1) begin
                  state_next = ret_reg;
               end
            end
            default: begin
               state_next = SCHED_PAIR;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= SCHED_PAIR;
         ret_reg       <= SCHED_PAIR;
         stall_ctr_reg <= '0;
         first_reg     <= 1'b0;
         dual_cnt_reg  <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         ret_reg       <= ret_next;
         stall_ctr_reg <= stall_ctr_next;
         if (issue1) begin
            first_reg <= 1'b1;
         end else if (issue0) begin
            first_reg <= 1'b0;
         end
         if (issue0 && issue1) begin
            dual_cnt_reg <= dual_cnt_reg + 1'b1;
         end
         // Flush bubbles are not hazard stalls and are not counted.
         if (bubble && !branch_taken) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
      end
   end

   assign first     = first_reg;
   assign dual_cnt  = dual_cnt_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule
